// File: rtl/lcd_avalon_initiator.sv
// Avalon-MM initiator for the character-LCD control slave: power-up wait, fixed
// HD44780 init sequence, then host bytes as setup/strobe/hold writes plus busy polls.
module lcd_avalon_initiator #(
  parameter int POWERUP_CYCLES = 750000,
  parameter int SETUP_CYCLES   = 2,
  parameter int E_CYCLES       = 13,
  parameter int HOLD_CYCLES    = 2,
  parameter int BUSY_TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       init_done,
  output logic       busy_timeout,
  output logic [1:0] address,
  output logic       read,
  output logic       write,
  output logic       begintransfer,
  output logic [7:0] writedata,
  input  logic [7:0] readdata
);

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, STROBE, HOLD} state_t;

  state_t      state, state_d;
  logic [31:0] cnt, cnt_d;
  logic [31:0] to_cnt, to_cnt_d;
  logic        poll, poll_d;
  logic [1:0]  idx, idx_d;
  logic        done_q, done_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        busy_s, busy_d;
  logic        bto_q, bto_d;
  logic        in_xfer;

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  assign in_xfer = (state == SETUP) || (state == STROBE) || (state == HOLD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= PWRUP;
      cnt    <= '0;
      to_cnt <= '0;
      poll   <= 1'b0;
      idx    <= '0;
      done_q <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= '0;
      busy_s <= 1'b0;
      bto_q  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      to_cnt <= to_cnt_d;
      poll   <= poll_d;
      idx    <= idx_d;
      done_q <= done_d;
      rs_q   <= rs_d;
      data_q <= data_d;
      busy_s <= busy_d;
      bto_q  <= bto_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    to_cnt_d = to_cnt;
    poll_d   = poll;
    idx_d    = idx;
    done_d   = done_q;
    rs_d     = rs_q;
    data_d   = data_q;
    busy_d   = busy_s;
    bto_d    = 1'b0;
    // cumulative poll clocks for the current transfer, this cycle included
    if (poll && in_xfer) to_cnt_d = to_cnt + 32'd1;
    case (state)
      PWRUP: begin
        if (cnt == 32'(POWERUP_CYCLES - 1)) begin
          cnt_d    = '0;
          idx_d    = '0;
          rs_d     = 1'b0;
          data_d   = init_byte(2'd0);
          poll_d   = 1'b0;
          to_cnt_d = '0;
          state_d  = SETUP;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      INIT: begin
        rs_d     = 1'b0;
        data_d   = init_byte(idx);
        poll_d   = 1'b0;
        to_cnt_d = '0;
        state_d  = SETUP;
      end
      IDLE: begin
        if (cmd_valid && done_q) begin
          rs_d     = cmd_rs;
          data_d   = cmd_data;
          poll_d   = 1'b0;
          to_cnt_d = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (cnt == 32'(SETUP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = STROBE;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      STROBE: begin
        if (cnt == 32'(E_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = HOLD;
          if (poll) busy_d = readdata[7];
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      HOLD: begin
        if (cnt == 32'(HOLD_CYCLES - 1)) begin
          cnt_d = '0;
          if (!poll) begin
            poll_d  = 1'b1;
            state_d = SETUP;
          end else if (busy_s && (to_cnt_d < 32'(BUSY_TIMEOUT))) begin
            state_d = SETUP;
          end else begin
            // busy still set here means the poll budget ran out
            bto_d = busy_s;
            if (done_q) begin
              state_d = IDLE;
            end else if (idx == 2'd3) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              idx_d   = idx + 2'd1;
              state_d = INIT;
            end
          end
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      default: state_d = PWRUP;
    endcase
  end

  // RW stays 1 outside a write so the slave keeps LCD_data tristated
  assign address       = (in_xfer && !poll) ? {rs_q, 1'b0} : 2'b01;
  assign write         = (state == STROBE) && !poll;
  assign read          = (state == STROBE) && poll;
  assign begintransfer = (state == STROBE) && (cnt == '0);
  assign writedata     = data_q;
  assign cmd_ready     = (state == IDLE) && done_q;
  assign init_done     = done_q;
  assign busy_timeout  = bto_q;

endmodule

// File: tb/tb_lcd_avalon_initiator.sv
// Directed bench: scoreboard of expected slave writes, busy-poll and timeout
// scenarios, reset mid-write, and host bytes held during init.
module tb_lcd_avalon_initiator;
  localparam int PWR = 10, S = 2, E = 3, H = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, cmd_valid, cmd_ready, cmd_rs, init_done, busy_timeout;
  logic       read, write, begintransfer;
  logic [1:0] address;
  logic [7:0] cmd_data, writedata, readdata;

  logic       reset_n_b, cmd_valid_b, cmd_ready_b, init_done_b, busy_timeout_b;
  logic       read_b, write_b, begintransfer_b, rd_b_busy;
  logic [1:0] address_b;
  logic [7:0] writedata_b, readdata_b;

  int vectors = 0, miscompares = 0;
  int wlen = 0, btlen = 0, reads_seen = 0, busy_polls = 0;
  int bto_a = 0, bto_b = 0, reads_b = 0, accepts = 0;
  logic [9:0] exp_q[$];

  assign readdata   = {(reads_seen <= busy_polls), 7'h0};
  assign readdata_b = {rd_b_busy, 7'h0};

  lcd_avalon_initiator #(.POWERUP_CYCLES(PWR), .SETUP_CYCLES(S), .E_CYCLES(E),
    .HOLD_CYCLES(H), .BUSY_TIMEOUT(1000)) dut_a (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data), .init_done(init_done),
    .busy_timeout(busy_timeout), .address(address), .read(read), .write(write),
    .begintransfer(begintransfer), .writedata(writedata), .readdata(readdata));

  lcd_avalon_initiator #(.POWERUP_CYCLES(PWR), .SETUP_CYCLES(S), .E_CYCLES(E),
    .HOLD_CYCLES(H), .BUSY_TIMEOUT(20)) dut_b (
    .clk(clk), .reset_n(reset_n_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_rs(1'b1), .cmd_data(8'h20), .init_done(init_done_b),
    .busy_timeout(busy_timeout_b), .address(address_b), .read(read_b), .write(write_b),
    .begintransfer(begintransfer_b), .writedata(writedata_b), .readdata(readdata_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor for dut_a: scoreboard pops, strobe widths, read/write exclusivity
  always @(posedge clk) begin
    if (reset_n && cmd_valid && cmd_ready) begin
      accepts++;
      chk("accept_after_init", {31'd0, init_done}, 1);
    end
    #1;
    if (!reset_n) begin
      wlen = 0;
      btlen = 0;
    end else begin
      if (read || write) chk("rw_exclusive", {31'd0, read & write}, 0);
      if (begintransfer && write) begin
        if (exp_q.size() == 0) chk("sb_nonempty", exp_q.size(), 1);
        else chk("sb_write", {22'd0, address, writedata}, {22'd0, exp_q.pop_front()});
      end
      if (begintransfer && read) begin
        reads_seen++;
        chk("poll_addr", {30'd0, address}, 1);
      end
      if (write) wlen++;
      else if (wlen != 0) begin
        chk("e_width", wlen, E);
        wlen = 0;
      end
      if (begintransfer) btlen++;
      else if (btlen != 0) begin
        chk("bt_width", btlen, 1);
        btlen = 0;
      end
      if (busy_timeout) bto_a++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (busy_timeout_b) bto_b++;
    if (begintransfer_b && read_b) reads_b++;
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, cmd_ready}, 1);
  endtask

  task automatic send(input logic rs, input logic [7:0] data);
    wait_ready("ready_before_send");
    exp_q.push_back({rs, 1'b0, data});
    cmd_rs = rs;
    cmd_data = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("ready_drop", {31'd0, cmd_ready}, 0);
  endtask

  // release reset_n and check the first init write edge position
  task automatic pwr_check();
    int n = 0;
    @(negedge clk);
    reset_n = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!write && n < 100);
    chk("first_write_edge", n, PWR + S);
    chk("first_write_data", {24'd0, writedata}, 32'h38);
    chk("first_write_addr", {30'd0, address}, 0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; reset_n_b = 1'b0;
    cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h00;
    cmd_valid_b = 1'b0; rd_b_busy = 1'b0;
    #22;
    chk("rst_address", {30'd0, address}, 1);
    chk("rst_rw", {30'd0, read, write}, 0);
    chk("rst_bt_wd", {23'd0, begintransfer, writedata}, 0);
    chk("rst_ready_done_bto", {29'd0, cmd_ready, init_done, busy_timeout}, 0);

    // init sequence, with 0x55 held valid throughout
    exp_q.push_back(10'h038); exp_q.push_back(10'h00C);
    exp_q.push_back(10'h001); exp_q.push_back(10'h006);
    exp_q.push_back(10'h055);
    cmd_rs = 1'b0; cmd_data = 8'h55; cmd_valid = 1'b1;
    reset_n_b = 1'b1;
    pwr_check();
    chk("no_accept_in_init", accepts, 0);
    wait_ready("ready_after_init");
    chk("done_with_ready", {31'd0, init_done}, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("ready_drop_55", {31'd0, cmd_ready}, 0);
    wait_ready("ready_after_55");
    chk("accept_once", accepts, 1);

    // character write: measure accept-to-ready
    exp_q.push_back(10'h241);
    cmd_rs = 1'b1; cmd_data = 8'h41; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wr_to_ready", n, 2 * (S + E + H));

    // three busy polls then ready
    @(negedge clk);
    reads_seen = 0; busy_polls = 3;
    send(1'b0, 8'h01);
    wait_ready("ready_after_busy");
    chk("busy_poll_count", reads_seen, 4);
    chk("no_timeout_a", bto_a, 0);
    busy_polls = 0;

    // reset while write is high
    send(1'b0, 8'h42);
    n = 0;
    while (!write && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("write_seen", {31'd0, write}, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rw", {30'd0, read, write}, 0);
    chk("mid_rst_addr", {30'd0, address}, 1);
    chk("mid_rst_done", {31'd0, init_done}, 0);
    exp_q.push_back(10'h038); exp_q.push_back(10'h00C);
    exp_q.push_back(10'h001); exp_q.push_back(10'h006);
    pwr_check();
    wait_ready("ready_after_reinit");
    chk("sb_drained", exp_q.size(), 0);

    // stuck-busy timeout on dut_b
    n = 0;
    while (!cmd_ready_b && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("b_ready", {31'd0, cmd_ready_b}, 1);
    reads_b = 0; rd_b_busy = 1'b1; cmd_valid_b = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_b = 1'b0;
    n = 0;
    while (!cmd_ready_b && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("b_ready_after_to", {31'd0, cmd_ready_b}, 1);
    chk("b_timeout_pulses", bto_b, 1);
    chk("b_poll_count", reads_b, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
